// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: default sizes,
// arbiter state encoding and the byte-address to word-index slice.
package dmem_pkg;

  localparam int DMEM_DW       = 64;
  localparam int DMEM_AW       = 64;
  localparam int DMEM_DEPTH    = 64;
  localparam int DMEM_MAX_LOCK = 4;

  // Word index lives in addr[31:2]; the low two bits must be zero.
  localparam int WIDX_HI = 31;
  localparam int WIDX_LO = 2;
  localparam int WIDX_W  = WIDX_HI - WIDX_LO + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Combinational two-way round-robin pick with lock-owner override.
// Produces a one-hot (or empty) grant vector.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic [1:0] gnt
);

  // A locked owner that still requests wins outright; otherwise the
  // requester that was not granted last time wins a tie.
  always_comb begin
    gnt = 2'b00;
    if (lock_valid && req[lock_owner]) begin
      gnt[lock_owner] = 1'b1;
    end else if (req == 2'b11) begin
      gnt[~last] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter and sequencer for the single-port dmem: round-robin
// with bounded burst lock, address checks and registered completions.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DW       = DMEM_DW,
  parameter int AW       = DMEM_AW,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int BW = $clog2(MAX_LOCK + 1);
  localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH);
  localparam logic [BW-1:0]     MAX_BEATS = BW'(MAX_LOCK);

  arb_state_t    state, state_next;
  logic          last, last_next;
  logic [BW-1:0] beats, beats_next, beats_inc;
  logic [1:0]    gnt;
  logic          granted, sel, sel_we, sel_lock, bad;
  logic          lock_valid, lock_owner;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] resp_data;

  assign lock_valid = (state != IDLE);
  assign lock_owner = (state == LOCK1);

  dmem_rr_pick u_pick (
    .req        ({req1, req0}),
    .last       (last),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .gnt        (gnt)
  );

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign granted = |gnt;
  assign sel     = gnt[1];

  assign sel_addr = sel ? addr1 : addr0;
  assign sel_we   = sel ? we1 : we0;
  assign sel_lock = sel ? lock1 : lock0;

  assign bad = (sel_addr[1:0] != 2'b00) ||
               (sel_addr[WIDX_HI:WIDX_LO] >= DEPTH_IDX);

  // Writes are suppressed while reset is held even though grants are not.
  assign mem_a  = sel_addr;
  assign mem_wd = sel ? wdata1 : wdata0;
  assign mem_we = rst_n & granted & sel_we & ~bad;

  assign resp_data = (!sel_we && !bad) ? mem_rd : '0;
  assign beats_inc = beats + BW'(1);

  always_comb begin
    state_next = state;
    beats_next = beats;
    last_next  = last;
    if (granted) begin
      last_next = sel;
      if (lock_valid && (sel == lock_owner)) begin
        if (!sel_lock || (beats_inc >= MAX_BEATS)) begin
          state_next = IDLE;
          beats_next = '0;
        end else begin
          beats_next = beats_inc;
        end
      end else if (sel_lock && (MAX_LOCK > 1)) begin
        state_next = sel ? LOCK1 : LOCK0;
        beats_next = BW'(1);
      end else begin
        state_next = IDLE;
        beats_next = '0;
      end
    end else begin
      state_next = IDLE;
      beats_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      beats <= '0;
    end else begin
      state <= state_next;
      last  <= last_next;
      beats <= beats_next;
    end
  end

  // The side that is not granted keeps its last read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt[0];
      rvalid1 <= gnt[1];
      err0    <= gnt[0] & bad;
      err1    <= gnt[1] & bad;
      if (gnt[0]) rdata0 <= resp_data;
      if (gnt[1]) rdata1 <= resp_data;
    end
  end

endmodule
